// File: rtl/spawn_pkg.sv
// Shared definitions for the object spawn sequencer: ROM word layout, descriptor
// payload, state encoding and a ROM-word unpack helper.
package spawn_pkg;

  localparam int unsigned ENTRY_W = 67;
  localparam int unsigned COUNT_W = 16;

  localparam int unsigned DIR_W   = 3;
  localparam int unsigned POS_W   = 10;
  localparam int unsigned SPEED_W = 5;
  localparam int unsigned DTIME_W = 8;
  localparam int unsigned DTRIG_W = 2;
  localparam int unsigned WAIT_W  = 8;

  localparam int unsigned DTRIG_LSB = 0;
  localparam int unsigned DTIME_LSB = 2;
  localparam int unsigned SPEED_LSB = 10;
  localparam int unsigned H_LSB     = 15;
  localparam int unsigned W_LSB     = 25;
  localparam int unsigned Y_LSB     = 35;
  localparam int unsigned X_LSB     = 45;
  localparam int unsigned DIR_LSB   = 55;
  localparam int unsigned WAIT_LSB  = 58;
  localparam int unsigned END_BIT   = 66;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    READ    = 3'd2,
    DELAY   = 3'd3,
    OFFER   = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6
  } state_e;

  // Descriptor as presented on the shared object bus
  typedef struct packed {
    logic [DIR_W-1:0]   dir;
    logic [POS_W-1:0]   x;
    logic [POS_W-1:0]   y;
    logic [POS_W-1:0]   w;
    logic [POS_W-1:0]   h;
    logic [SPEED_W-1:0] speed;
    logic [DTIME_W-1:0] dtime;
    logic [DTRIG_W-1:0] dtrig;
  } desc_t;

  typedef struct packed {
    logic              last;
    logic [WAIT_W-1:0] wait_cs;
    desc_t             desc;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] word);
    entry_t e;
    e.last       = word[END_BIT];
    e.wait_cs    = word[WAIT_LSB  +: WAIT_W];
    e.desc.dir   = word[DIR_LSB   +: DIR_W];
    e.desc.x     = word[X_LSB     +: POS_W];
    e.desc.y     = word[Y_LSB     +: POS_W];
    e.desc.w     = word[W_LSB     +: POS_W];
    e.desc.h     = word[H_LSB     +: POS_W];
    e.desc.speed = word[SPEED_LSB +: SPEED_W];
    e.desc.dtime = word[DTIME_LSB +: DTIME_W];
    e.desc.dtrig = word[DTRIG_LSB +: DTRIG_W];
    return e;
  endfunction

endpackage

// File: rtl/spawn_delay_counter.sv
// Loadable centisecond down-counter; load wins over a same-cycle tick, and the
// count parks at zero.
module spawn_delay_counter
  import spawn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              tick_en,
  output logic              zero_c
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/object_spawn_sequencer.sv
// Walks the pattern ROM, waits each entry's delay, and hands descriptors to the
// collider runtime over the sync/update handshake. SPAWN_LOOP_EN: replay on wrap.
module object_spawn_sequencer
  import spawn_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk_calculation,
  input  logic                reset,
  input  logic                start,
  input  logic                tick_centi,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [ENTRY_W-1:0]  rom_data,
  output logic [DIR_W-1:0]    object_movement_direction,
  output logic [POS_W-1:0]    object_pos_x,
  output logic [POS_W-1:0]    object_pos_y,
  output logic [POS_W-1:0]    object_w,
  output logic [POS_W-1:0]    object_h,
  output logic [SPEED_W-1:0]  object_speed,
  output logic [DTIME_W-1:0]  object_destroy_time,
  output logic [DTRIG_W-1:0]  object_destroy_trigger,
  output logic                sync_object_position,
  input  logic                update_object_position,
  output logic                busy,
  output logic                pattern_done,
  output logic [COUNT_W-1:0]  spawn_count
);

`ifdef SPAWN_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  desc_t              hold_q, hold_d;
  desc_t              desc_q, desc_d;
  logic               sync_q, sync_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] count_q, count_d;

  entry_t rom_entry_c;
  logic   ctr_load_c;
  logic   ctr_tick_c;
  logic   ctr_zero_c;
  logic   wrap_c;

  assign rom_entry_c = unpack_entry(rom_data);
  assign ctr_tick_c  = tick_centi && (state_q == DELAY);

  spawn_delay_counter u_delay (
    .clk      (clk_calculation),
    .rst      (reset),
    .load     (ctr_load_c),
    .load_val (rom_entry_c.wait_cs),
    .tick_en  (ctr_tick_c),
    .zero_c   (ctr_zero_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    desc_d     = desc_q;
    sync_d     = 1'b1;
    count_d    = count_q;
    ctr_load_c = 1'b0;
    wrap_c     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          count_d = '0;
        end
      end
      FETCH: begin
        state_d = READ;
      end
      READ: begin
        hold_d = rom_entry_c.desc;
        if (rom_entry_c.last) begin
          // An end marker at address 0 always stops, so an empty pattern cannot spin
          if (LOOP_EN && (addr_q != '0)) begin
            state_d = FETCH;
            addr_d  = '0;
            wrap_c  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          ctr_load_c = 1'b1;
          state_d    = DELAY;
        end
      end
      DELAY: begin
        if (ctr_zero_c) begin
          state_d = OFFER;
          desc_d  = hold_q;
          sync_d  = 1'b0;
        end
      end
      OFFER: begin
        if (update_object_position) begin
          state_d = RELEASE;
          if (count_q != '1) begin
            count_d = count_q + COUNT_W'(1);
          end
        end else begin
          sync_d = 1'b0;
        end
      end
      RELEASE: begin
        if (!update_object_position) begin
          if (addr_q == ADDR_LAST) begin
            if (LOOP_EN) begin
              state_d = FETCH;
              addr_d  = '0;
              wrap_c  = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d = FETCH;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE) || wrap_c;
  end

  always_ff @(posedge clk_calculation) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      desc_q  <= '0;
      sync_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      desc_q  <= desc_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign rom_addr                  = addr_q;
  assign object_movement_direction = desc_q.dir;
  assign object_pos_x              = desc_q.x;
  assign object_pos_y              = desc_q.y;
  assign object_w                  = desc_q.w;
  assign object_h                  = desc_q.h;
  assign object_speed              = desc_q.speed;
  assign object_destroy_time       = desc_q.dtime;
  assign object_destroy_trigger    = desc_q.dtrig;
  assign sync_object_position      = sync_q;
  assign busy                      = busy_q;
  assign pattern_done              = done_q;
  assign spawn_count               = count_q;

endmodule

// File: tb/tb_object_spawn_sequencer.sv
// Scoreboard bench for object_spawn_sequencer: a synchronous ROM model and an
// inline runtime responder that pops expected descriptors as offers appear.
module tb_object_spawn_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        tick_centi;
  logic [7:0]  rom_addr;
  logic [66:0] rom_data;
  logic [2:0]  dir_o;
  logic [9:0]  x_o, y_o, w_o, h_o;
  logic [4:0]  speed_o;
  logic [7:0]  dtime_o;
  logic [1:0]  dtrig_o;
  logic        sync_o;
  logic        ack;
  logic        busy_o;
  logic        done_o;
  logic [15:0] count_o;
  logic [57:0] dbus;

  logic [66:0] rom [0:255];

  typedef struct {
    logic [57:0] desc;
    logic [15:0] count;
    logic [7:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  assign dbus = {dir_o, x_o, y_o, w_o, h_o, speed_o, dtime_o, dtrig_o};

  object_spawn_sequencer dut (
    .clk_calculation           (clk),
    .reset                     (reset),
    .start                     (start),
    .tick_centi                (tick_centi),
    .rom_addr                  (rom_addr),
    .rom_data                  (rom_data),
    .object_movement_direction (dir_o),
    .object_pos_x              (x_o),
    .object_pos_y              (y_o),
    .object_w                  (w_o),
    .object_h                  (h_o),
    .object_speed              (speed_o),
    .object_destroy_time       (dtime_o),
    .object_destroy_trigger    (dtrig_o),
    .sync_object_position      (sync_o),
    .update_object_position    (ack),
    .busy                      (busy_o),
    .pattern_done              (done_o),
    .spawn_count               (count_o)
  );

`ifdef SPAWN_LOOP_EN
  int done_hi = 0;
  always @(negedge clk) if (done_o === 1'b1) done_hi++;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [57:0] mk_desc(input logic [2:0] d, input logic [9:0] x,
                                          input logic [9:0] y, input logic [9:0] w,
                                          input logic [9:0] h, input logic [4:0] s,
                                          input logic [7:0] t, input logic [1:0] g);
    return {d, x, y, w, h, s, t, g};
  endfunction

  function automatic logic [66:0] mk_entry(input logic last, input logic [7:0] wt,
                                           input logic [57:0] d);
    return {last, wt, d};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic push(input logic [57:0] d, input logic [15:0] c, input logic [7:0] a);
    exp_t e;
    e.desc  = d;
    e.count = c;
    e.addr  = a;
    sb.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Runtime model: wait for an offer, compare it, ack after ack_dly, hold ack ack_hold extra cycles
  task automatic serve(input int ack_dly, input int ack_hold, output int lat);
    exp_t e;
    lat = 0;
    while (sync_o === 1'b1 && lat < 400) begin
      step(1);
      lat++;
    end
    chk("offer_seen", 64'(sync_o), 64'd0);
    if (sync_o !== 1'b0) return;
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("desc", 64'(dbus), 64'(e.desc));
    chk("offer_addr", 64'(rom_addr), 64'(e.addr));
    for (int i = 0; i < ack_dly; i++) begin
      step(1);
      chk("offer_sync", 64'(sync_o), 64'd0);
      chk("offer_desc", 64'(dbus), 64'(e.desc));
    end
    ack = 1'b1;
    step(1);
    chk("ack_sync", 64'(sync_o), 64'd1);
    chk("count", 64'(count_o), 64'(e.count));
    for (int i = 0; i < ack_hold; i++) begin
      step(1);
      chk("hold_sync", 64'(sync_o), 64'd1);
      chk("hold_addr", 64'(rom_addr), 64'(e.addr));
    end
    ack = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic [15:0] cnt);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk("done", 64'(done_o), 64'd1);
    chk("done_busy", 64'(busy_o), 64'd0);
    chk("final_count", 64'(count_o), 64'(cnt));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [57:0] d0, da, db;
    int lat;
    int n;

    reset = 1'b1;
    start = 1'b0;
    tick_centi = 1'b0;
    ack = 1'b0;
    clear_rom();
    step(3);
    chk("rst_sync", 64'(sync_o), 64'd1);
    chk("rst_desc", 64'(dbus), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    reset = 1'b0;
    step(2);

    // Single entry then terminator, ack two cycles after sync falls
    d0 = mk_desc(3'd2, 10'd100, 10'd200, 10'd40, 10'd8, 5'd3, 8'd50, 2'd1);
    rom[0] = mk_entry(1'b0, 8'd0, d0);
    rom[1] = mk_entry(1'b1, 8'd0, '0);
    push(d0, 16'd1, 8'd0);
    do_start();
    chk("t1_busy", 64'(busy_o), 64'd1);
    serve(2, 0, lat);
    chk("t1_latency", 64'(lat), 64'd3);
    wait_done(20, 16'd1);
    chk("t1_desc_hold", 64'(dbus), 64'(d0));

    // wait=5: tick in the load cycle ignored, offer follows the 5th counted tick
    clear_rom();
    d0 = mk_desc(3'd1, 10'd5, 10'd6, 10'd7, 10'd8, 5'd9, 8'd10, 2'd3);
    rom[0] = mk_entry(1'b0, 8'd5, d0);
    rom[1] = mk_entry(1'b1, 8'd0, '0);
    push(d0, 16'd1, 8'd0);
    do_start();
    step(1);
    tick_centi = 1'b1;
    step(1);
    tick_centi = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(9);
      chk("t2_before_tick", 64'(sync_o), 64'd1);
      tick_centi = 1'b1;
      step(1);
      tick_centi = 1'b0;
    end
    chk("t2_pre_offer", 64'(sync_o), 64'd1);
    step(1);
    chk("t2_offer_edge", 64'(sync_o), 64'd0);
    serve(1, 0, lat);
    chk("t2_no_extra_wait", 64'(lat), 64'd0);
    wait_done(20, 16'd1);

    // Slow ack (50 cycles), ack held 3 cycles in RELEASE, start while busy ignored
    clear_rom();
    da = mk_desc(3'd3, 10'd321, 10'd123, 10'd16, 10'd32, 5'd31, 8'd255, 2'd2);
    db = mk_desc(3'd7, 10'd1023, 10'd0, 10'd512, 10'd1, 5'd1, 8'd1, 2'd0);
    rom[0] = mk_entry(1'b0, 8'd0, da);
    rom[1] = mk_entry(1'b0, 8'd0, db);
    rom[2] = mk_entry(1'b1, 8'd0, '0);
    push(da, 16'd1, 8'd0);
    push(db, 16'd2, 8'd1);
    do_start();
    serve(50, 3, lat);
    do_start();
    serve(1, 0, lat);
    wait_done(20, 16'd2);

    // Reset during the second entry's offer, then replay from address 0
    do_start();
    push(da, 16'd1, 8'd0);
    serve(1, 0, lat);
    n = 0;
    while (sync_o === 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    chk("t4_second_offer", 64'(sync_o), 64'd0);
    chk("t4_count_pre", 64'(count_o), 64'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t4_sync", 64'(sync_o), 64'd1);
    chk("t4_desc", 64'(dbus), 64'd0);
    chk("t4_busy", 64'(busy_o), 64'd0);
    chk("t4_count", 64'(count_o), 64'd0);
    chk("t4_addr", 64'(rom_addr), 64'd0);
    step(3);
    chk("t4_idle", 64'(busy_o | done_o), 64'd0);
    push(da, 16'd1, 8'd0);
    push(db, 16'd2, 8'd1);
    do_start();
    serve(1, 0, lat);
    serve(1, 0, lat);
    wait_done(20, 16'd2);

    // Full ROM with no terminator: implicit stop after address 255
    for (int i = 0; i < 256; i++) begin
      d0 = mk_desc(3'(i), 10'(i), 10'(255 - i), 10'(i * 3), 10'(i ^ 8'h5a), 5'(i), 8'(i), 2'(i));
      rom[i] = mk_entry(1'b0, 8'd0, d0);
      push(d0, 16'(i + 1), 8'(i));
    end
`ifndef SPAWN_LOOP_EN
    do_start();
    for (int i = 0; i < 256; i++) serve(1, 0, lat);
    wait_done(20, 16'd256);
`else
    sb.delete();
`endif

    // Terminator at address 0 always stops
    clear_rom();
    rom[0] = mk_entry(1'b1, 8'd0, '0);
    do_start();
    wait_done(20, 16'd0);

`ifdef SPAWN_LOOP_EN
    // Two entries then terminator: replays 0,1,0,1 with one done pulse per wrap
    rom[0] = mk_entry(1'b0, 8'd0, da);
    rom[1] = mk_entry(1'b0, 8'd0, db);
    rom[2] = mk_entry(1'b1, 8'd0, '0);
    push(da, 16'd1, 8'd0);
    push(db, 16'd2, 8'd1);
    push(da, 16'd3, 8'd0);
    push(db, 16'd4, 8'd1);
    do_start();
    done_hi = 0;
    for (int i = 0; i < 4; i++) serve(1, 0, lat);
    chk("loop_done_pulses", 64'(done_hi), 64'd1);
    chk("loop_busy", 64'(busy_o), 64'd1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
